// File: rtl/pc_sequencer_if.sv
// Control-unit to PC-sequencer bus: commit strobe, PC-source controls, flags,
// and the sequencer's PC and stack status.
interface pc_sequencer_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int STACK_DEPTH = 8
);
    localparam int CW = $clog2(STACK_DEPTH) + 1;

    logic                  write_pc;
    logic [2:0]            branch;
    logic                  push;
    logic                  pop;
    logic                  add_pc;
    logic                  brfl_control;
    logic [3:0]            flags;
    logic [3:0]            flag_mask;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  halted;
    logic                  stack_ovf;
    logic                  stack_unf;
    logic [CW-1:0]         stack_count;

    modport master (
        output write_pc, branch, push, pop, add_pc, brfl_control,
               flags, flag_mask, target,
        input  pc, halted, stack_ovf, stack_unf, stack_count
    );

    modport slave (
        input  write_pc, branch, push, pop, add_pc, brfl_control,
               flags, flag_mask, target,
        output pc, halted, stack_ovf, stack_unf, stack_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with a hardware call/return stack, flag branches and a
// sticky halt; all state changes on a rising edge of the commit strobe.
module pc_sequencer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int STACK_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_sequencer_if.slave    bus
);
    localparam int CW = $clog2(STACK_DEPTH) + 1;
    localparam int PW = $clog2(STACK_DEPTH);

    localparam logic [2:0] BR_JUMP = 3'b010;
    localparam logic [2:0] BR_FLAG = 3'b100;
    localparam logic [2:0] BR_HALT = 3'b101;

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t                state_r, state_n_s;
    logic [ADDR_WIDTH-1:0] pc_r, pc_n_s;
    logic [CW-1:0]         count_r, count_n_s;
    logic                  ovf_r, ovf_n_s;
    logic                  unf_r, unf_n_s;
    logic                  write_pc_q_r;
    logic                  armed_r;
    logic [ADDR_WIDTH-1:0] stack_r [STACK_DEPTH];

    logic                  commit_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  flag_hit_s;
    logic [PW-1:0]         top_idx_s;
    logic [ADDR_WIDTH-1:0] pc_inc_s;
    logic                  stack_we_s;
    logic [PW-1:0]         stack_wa_s;

    // armed_r blocks a strobe that was already high when reset released.
    assign commit_s   = bus.write_pc & ~write_pc_q_r & armed_r;
    assign full_s     = (count_r == CW'(STACK_DEPTH));
    assign empty_s    = (count_r == CW'(1'b0));
    assign flag_hit_s = |(bus.flags & bus.flag_mask);
    assign top_idx_s  = count_r[PW-1:0] - PW'(1'b1);
    assign pc_inc_s   = pc_r + ADDR_WIDTH'(1'b1);
    assign stack_wa_s = count_r[PW-1:0];

    // Next-state and commit action decode, first matching action wins.
    always_comb begin
        state_n_s  = state_r;
        pc_n_s     = pc_r;
        count_n_s  = count_r;
        ovf_n_s    = ovf_r;
        unf_n_s    = unf_r;
        stack_we_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (commit_s) begin
                    if (bus.branch == BR_HALT) begin
                        state_n_s = ST_HALT;
                    end else if (bus.push) begin
                        if (!full_s) begin
                            stack_we_s = 1'b1;
                            count_n_s  = count_r + CW'(1'b1);
                            pc_n_s     = bus.target;
                        end else begin
                            ovf_n_s = 1'b1;
                            pc_n_s  = pc_inc_s;
                        end
                    end else if (bus.pop) begin
                        if (!empty_s) begin
                            count_n_s = count_r - CW'(1'b1);
                            pc_n_s    = stack_r[top_idx_s] + ADDR_WIDTH'(bus.add_pc);
                        end else begin
                            unf_n_s = 1'b1;
                            pc_n_s  = pc_inc_s;
                        end
                    end else if (bus.branch == BR_JUMP) begin
                        pc_n_s = bus.target;
                    end else if ((bus.branch == BR_FLAG) && bus.brfl_control && flag_hit_s) begin
                        pc_n_s = bus.target;
                    end else begin
                        pc_n_s = pc_inc_s;
                    end
                end else begin
                    state_n_s = ST_RUN;
                end
            end
            ST_HALT: state_n_s = ST_HALT;
            default: state_n_s = ST_RUN;
        endcase
    end

    // Architectural state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_RUN;
            pc_r         <= {ADDR_WIDTH{1'b0}};
            count_r      <= {CW{1'b0}};
            ovf_r        <= 1'b0;
            unf_r        <= 1'b0;
            write_pc_q_r <= 1'b0;
            armed_r      <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            pc_r         <= pc_n_s;
            count_r      <= count_n_s;
            ovf_r        <= ovf_n_s;
            unf_r        <= unf_n_s;
            write_pc_q_r <= bus.write_pc;
            armed_r      <= armed_r | ~bus.write_pc;
        end
    end

    // Return-stack storage; validity is tracked by count_r alone.
    always_ff @(posedge clk) begin
        if (stack_we_s) begin
            stack_r[stack_wa_s] <= pc_r;
        end
    end

    assign bus.pc          = pc_r;
    assign bus.halted      = (state_r == ST_HALT);
    assign bus.stack_ovf   = ovf_r;
    assign bus.stack_unf   = unf_r;
    assign bus.stack_count = count_r;
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and return-address sequencer for the MUSA core. It is the consumer of the control unit's PC-side control signals: `write_pc`, `branch`, `push`, `pop`, `add_pc` and `brfl_control`. It holds the architectural PC and a hardware call/return stack, and evaluates flag branches. It enters a sticky halt state on `halt`, and the fetch stage reads `pc` from this block.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC / target width; PC arithmetic is modulo 2^ADDR_WIDTH.
- STACK_DEPTH, 8, return-stack entries; must be a power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- write_pc  in  1  instruction-commit strobe from the control unit.
- branch  in  3  PC source code: 000 sequential, 010 jump, 100 flag branch, 101 halt; any other code is treated as sequential.
- push  in  1  call: save PC and jump to target.
- pop  in  1  return: reload PC from the stack.
- add_pc  in  1  on pop, the reloaded PC is top-of-stack + 1; when 0, it is top-of-stack.
- brfl_control  in  1  qualifies branch code 100.
- flags  in  4  ALU flag register.
- flag_mask  in  4  flag-test mask from the instruction.
- target  in  ADDR_WIDTH  jump / call / branch destination, already selected by the datapath.
- pc  out  ADDR_WIDTH  current PC, registered.
- halted  out  1  sticky halt indicator.
- stack_ovf  out  1  sticky: push attempted while the stack was full.
- stack_unf  out  1  sticky: pop attempted while the stack was empty.
- stack_count  out  $clog2(STACK_DEPTH)+1  number of occupied entries.

## Operation
- **Commit detection.**
  - A commit happens only on a 0->1 transition of `write_pc`, detected against a registered copy `write_pc_q`.
  - `write_pc` held high for N cycles produces exactly one commit.
  - All other inputs are sampled in the commit cycle only; outside a commit they are don't-care.
- **State machine.** Two states, RUN and HALT.
  - RUN -> HALT on a commit with branch=101. PC is unchanged.
  - HALT is left only by reset. While in HALT, commits are ignored: no PC, stack or flag change.
- **Commit actions in RUN**, first match wins:
  1. branch=101: halt, as above.
  2. push=1 (pop is ignored if also high):
     - stack not full: stack[count] <= pc, count++, pc <= target.
     - stack full: stack_ovf <= 1, pc <= pc+1, stack unchanged.
  3. pop=1:
     - stack not empty: count--, pc <= stack[count-1] + add_pc.
     - stack empty: stack_unf <= 1, pc <= pc+1.
  4. branch=010: pc <= target.
  5. branch=100:
     - brfl_control=1 and (flags & flag_mask) != 0: pc <= target.
     - otherwise: pc <= pc+1.
  6. Otherwise: pc <= pc+1.
- **Arithmetic.** `pc+1` and `top+add_pc` wrap, so all-ones + 1 = 0.
- **Stack.** The stack is LIFO; storage contents are not reset. Only `count` governs validity.

## Timing
- **Reset.** Asynchronous assertion sets: pc=0, halted=0, stack_ovf=0, stack_unf=0, stack_count=0, write_pc_q=0, state RUN.
- **Reset release.** A `write_pc` already high at release does not commit; it must first be seen low.
- **Mid-operation reset.** Reset asserted mid-program discards the stack and returns to the reset values immediately, without waiting for a clock.
- **Latency.** Commit sampled at posedge k; new pc, count and flags are visible after edge k, i.e. one-cycle latency. No combinational path from inputs to outputs.
- **Back-to-back commits.** The earliest next commit is 2 cycles later (write_pc high, low, high).
- **Same-cycle push after pop.** A push in the commit right after a pop writes the slot just freed.
- **Sticky flags.** stack_ovf and stack_unf clear only on reset.

## Test plan
- **Reset and sequential run:** assert rst_n=0 with no clock running -> pc=0 and all flags 0. Then 3 commits with branch=000 -> pc=3. Holding write_pc high for 5 cycles -> pc advances by exactly 1.
- **Jump and flag branch:**
  - branch=010, target=0x40 -> pc=0x40.
  - branch=100, brfl_control=1, flags=0010, mask=0010, target=0x80 -> pc=0x80.
  - Same with mask=0100 -> pc=0x81.
- **Call/return:**
  - pc=0x10, push, target=0x100 -> pc=0x100, count=1.
  - pop with add_pc=1 -> pc=0x11, count=0.
  - Repeat with add_pc=0 -> pc=0x10.
- **Stack boundaries:**
  - 8 nested pushes -> count=8. A 9th push -> stack_ovf=1, pc=previous+1, count=8.
  - 8 pops -> addresses returned in reverse order. A 9th pop -> stack_unf=1, pc+1.
- **Halt:** commit with branch=101 at pc=0x20 -> halted=1, pc=0x20. Further commits with push/jump -> no change. Reset -> pc=0, halted=0.
- **Wrap and priority:**
  - pc=all-ones, sequential commit -> pc=0.
  - push=pop=1 with branch=010 -> push executed, count+1, pc=target.
